alu_serial_seq: RTL and testbench

//  Bit-serial ALU sequencer. Issues one WIDTH-bit operation to a single 1-bit ALU slice,
//  one bit per clock, LSB first, and collects the result bits.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_bit_slice.sv | 44 ++++
 rtl/alu_serial_seq.sv | 149 ++++++++++++++
 tb/tb_alu_serial_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer and its 1-bit slice.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_NOR  = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    // Only the arithmetic operations produce a meaningful carry out.
    function automatic logic op_has_carry(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: NAND, NOR, ADD, SUB (SUB = a + ~b + cin).
module alu_bit_slice
    import alu_pkg::*;
(
    output logic       z,
    output logic       cout,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] s_op
);

    logic b_inv_s;

    // Bit result and carry out for the selected operation.
    always_comb begin
        z       = 1'b0;
        cout    = 1'b0;
        b_inv_s = ~b;
        case (s_op)
            OP_NAND: begin
                z    = ~(a & b);
                cout = 1'b0;
            end
            OP_NOR: begin
                z    = ~(a | b);
                cout = 1'b0;
            end
            OP_ADD: begin
                z    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                z    = a ^ b_inv_s ^ cin;
                cout = (a & b_inv_s) | (a & cin) | (b_inv_s & cin);
            end
            default: begin
                z    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs a WIDTH-bit op through one 1-bit slice,
// LSB first, one bit per clock, carrying between bits in a register.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       s_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    alu_op_e          op_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] z_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             ready_s;
    logic             accept_s;
    logic             last_s;
    logic             slice_z_s;
    logic             slice_cout_s;

    assign ready_s  = (state_r == IDLE) || (state_r == DONE);
    assign accept_s = start && ready_s;
    assign last_s   = (state_r == RUN) && (cnt_r == CNT_LAST);

    alu_bit_slice u_slice (
        .z    (slice_z_s),
        .cout (slice_cout_s),
        .a    (a_r[cnt_r]),
        .b    (b_r[cnt_r]),
        .cin  (carry_r),
        .s_op (op_r)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (accept_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode, taken from the next state so busy/done can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            RUN:     busy_nxt_s = 1'b1;
            DONE:    done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand capture on accept, then one result bit and carry update per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= OP_NAND;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            z_r     <= '0;
            cout_r  <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= alu_op_e'(s_op);
            carry_r <= cin;
            cnt_r   <= '0;
            z_r     <= '0;
            cout_r  <= 1'b0;
        end else if (state_r == RUN) begin
            z_r[cnt_r] <= slice_z_s;
            carry_r    <= slice_cout_s;
            // Counter parks on the last bit rather than wrapping.
            if (last_s) begin
                cnt_r  <= cnt_r;
                cout_r <= op_has_carry(op_r) ? slice_cout_s : 1'b0;
            end else begin
                cnt_r  <= cnt_r + CNT_W'(1);
                cout_r <= cout_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign z    = z_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq at WIDTH=4.
module tb_alu_serial_seq;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       s_op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             cout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s_op  (s_op),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .cout  (cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at the falling edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] aa, input logic [3:0] bb,
                         input logic ci);
        @(negedge clk);
        start = 1'b1;
        s_op  = op;
        a     = aa;
        b     = bb;
        cin   = ci;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count rising edges until done is seen, bounded.
    task automatic wait_done(output int k);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [3:0] aa,
                             input logic [3:0] bb, input logic ci,
                             input logic [3:0] ez, input logic ec);
        int k;
        issue(op, aa, bb, ci);
        check_eq({tag, "_busy"}, busy, 1'b1);
        wait_done(k);
        check_eq({tag, "_lat"}, k, 4);
        check_eq({tag, "_z"}, z, ez);
        check_eq({tag, "_cout"}, cout, ec);
        check_eq({tag, "_busy_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_1cyc"}, done, 1'b0);
        check_eq({tag, "_z_hold"}, z, ez);
        check_eq({tag, "_cout_hold"}, cout, ec);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'b0000;
        b     = 4'b0000;
        cin   = 1'b0;
        s_op  = 2'b00;
        #12;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_z", z, 4'b0000);
        check_eq("rst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_check("add",  2'b10, 4'b0101, 4'b0011, 1'b1 ^ 1'b1, 4'b1000, 1'b0);
        run_check("sub1", 2'b11, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);
        run_check("sub2", 2'b11, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
        run_check("nand", 2'b00, 4'b1100, 4'b1010, 1'b0, 4'b0111, 1'b0);
        run_check("nor",  2'b01, 4'b1100, 4'b1010, 1'b0, 4'b0001, 1'b0);

        // Carry-out wrap, then a new request in the DONE cycle.
        issue(2'b10, 4'b1111, 4'b0001, 1'b0);
        wait_done(k);
        check_eq("wrap_lat", k, 4);
        check_eq("wrap_z", z, 4'b0000);
        check_eq("wrap_cout", cout, 1'b1);
        start = 1'b1;
        s_op  = 2'b10;
        a     = 4'b0001;
        b     = 4'b0001;
        cin   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq("b2b_busy", busy, 1'b1);
        check_eq("b2b_done_low", done, 1'b0);
        check_eq("b2b_cout_clr", cout, 1'b0);
        wait_done(k);
        check_eq("b2b_lat", k, 4);
        check_eq("b2b_z", z, 4'b0010);
        check_eq("b2b_cout", cout, 1'b0);

        // start during RUN must be ignored.
        issue(2'b10, 4'b0101, 4'b0011, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        s_op  = 2'b00;
        a     = 4'b1111;
        b     = 4'b1111;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(k);
        check_eq("ign_lat", k, 2);
        check_eq("ign_z", z, 4'b1000);
        check_eq("ign_cout", cout, 1'b0);

        // Reset in the middle of an op.
        issue(2'b00, 4'b1100, 4'b1010, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1'b1);
        check_eq("mid_partial_z", z, 4'b0011);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_z", z, 4'b0000);
        check_eq("abort_cout", cout, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", done, 1'b0);
        end
        check_eq("abort_idle_busy", busy, 1'b0);
        run_check("post_rst", 2'b10, 4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
